bios_fetch: RTL and testbench

Instruction-fetch front end that drives the instruction read port (port A) of the BIOS memory and forms the fetch/decode boundary of the 3-stage core. It owns the fetch PC and issues one word address per cycle. It absorbs the memory's fixed 1-cycle registered read latency and presents {inst, pc, valid} to decode. It handles decode back-pressure (stall) with a one-entry hold buffer and control-flow redirects by squashing the in-flight fetch.

---
 rtl/bios_fetch.sv | 112 +++++++++++
 tb/tb_bios_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bios_fetch.sv
// Purpose  : instruction-fetch front end driving BIOS port A; presents {inst, pc, valid} to decode.
// Latency  : an address issued in cycle t is presented valid in cycle t+1; a redirect costs one NOP bubble.
// Backpress: stall freezes the PC and parks the presented word in a one-entry hold buffer until release.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   stall             decode cannot accept the presented inst this cycle
//   redirect/_pc      restart fetch at redirect_pc (low two bits ignored)
//   bios_adra         word address to BIOS port A (purely from the fetch PC)
//   bios_douta        BIOS port A read data, one cycle after the address
//   inst/inst_pc      instruction and its byte PC; inst is NOP when not valid
//   inst_valid        inst/inst_pc carry a real fetched instruction
module bios_fetch #(
  parameter int              XLEN       = 32,
  parameter int              ADDR_WIDTH = 12,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic [ADDR_WIDTH-1:0] bios_adra,
  input  logic [XLEN-1:0]       bios_douta,
  output logic [XLEN-1:0]       inst,
  output logic [XLEN-1:0]       inst_pc,
  output logic                  inst_valid
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  // Fetch PC and the PC/valid tag of the word currently on bios_douta.
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            v_q, v_d;

  // One-entry hold buffer used while decode is stalled.
  logic            holding_q, holding_d;
  logic [XLEN-1:0] hold_inst_q, hold_inst_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            hold_v_q, hold_v_d;

  logic [XLEN-1:0] pres_inst;
  logic [XLEN-1:0] pres_pc;
  logic            pres_v;

  // Address depends on the fetch PC alone, keeping stall/redirect off the memory address path.
  assign bios_adra = pc_f_q[ADDR_WIDTH+1:2];

  // While holding, the memory has been re-reading pc_f, so its data is not the parked word.
  assign pres_inst = holding_q ? hold_inst_q : bios_douta;
  assign pres_pc   = holding_q ? hold_pc_q   : pc_q;
  assign pres_v    = holding_q ? hold_v_q    : v_q;

  assign inst       = pres_v ? pres_inst : NOP;
  assign inst_pc    = pres_pc;
  assign inst_valid = pres_v;

  always_comb begin
    pc_f_d      = pc_f_q;
    pc_d        = pc_q;
    v_d         = v_q;
    holding_d   = holding_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    hold_v_d    = hold_v_q;

    if (redirect) begin
      // The word returning next cycle belongs to the old path and is squashed.
      pc_f_d    = redirect_pc & ~XLEN'(3);
      pc_d      = pc_f_q;
      v_d       = 1'b0;
      holding_d = 1'b0;
      hold_v_d  = 1'b0;
    end else if (stall) begin
      // Capture only on the first stall cycle; later cycles keep the parked word.
      if (!holding_q) begin
        holding_d   = 1'b1;
        hold_inst_d = pres_inst;
        hold_pc_d   = pres_pc;
        hold_v_d    = pres_v;
      end
    end else begin
      // Presented word is consumed; the word fetched at pc_f arrives next cycle.
      pc_d      = pc_f_q;
      v_d       = 1'b1;
      pc_f_d    = pc_f_q + XLEN'(4);
      holding_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q      <= RESET_PC;
      pc_q        <= RESET_PC;
      v_q         <= 1'b0;
      holding_q   <= 1'b0;
      hold_inst_q <= NOP;
      hold_pc_q   <= RESET_PC;
      hold_v_q    <= 1'b0;
    end else begin
      pc_f_q      <= pc_f_d;
      pc_q        <= pc_d;
      v_q         <= v_d;
      holding_q   <= holding_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      hold_v_q    <= hold_v_d;
    end
  end

endmodule

// File: tb/tb_bios_fetch.sv
// Purpose  : self-checking bench for bios_fetch against a stream-level model of the presented instructions.
// Latency  : model tracks the presented PC and the next PC to present; memory latency and hold buffer are implicit.
// Backpress: stall keeps the presented instruction; redirect inserts one invalid cycle before the target.
module tb_bios_fetch;

  localparam int          AW  = 12;
  localparam logic [31:0] RST = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] bios_adra;
  logic [31:0]   bios_douta;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bios_fetch #(.XLEN(32), .ADDR_WIDTH(AW), .RESET_PC(RST)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bios_adra  (bios_adra),
    .bios_douta (bios_douta),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

  // BIOS memory with a registered one-cycle read on port A.
  logic [31:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC000_0000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
  end
  always @(posedge clk) bios_douta <= mem[bios_adra];

  function automatic logic [AW-1:0] idx(input logic [31:0] pc);
    return pc[AW+1:2];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: what decode must see, from the rules alone.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = RST;
      m_next  = RST;
    end else if (redirect) begin
      m_valid = 1'b0;
      m_next  = redirect_pc & ~32'h3;
    end else if (!stall) begin
      m_valid = 1'b1;
      m_pc    = m_next;
      m_next  = m_next + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_adra", 32'(bios_adra), 32'(idx(m_next)));
      cmp("model_valid", 32'(inst_valid), 32'(m_valid));
      cmp("model_inst", inst, m_valid ? mem[idx(m_pc)] : NOP);
      if (m_valid) cmp("model_pc", inst_pc, m_pc);
    end
  end

  task automatic step(input logic s, input logic r, input logic rd, input logic [31:0] tgt);
    stall = s; reset = r; redirect = rd; redirect_pc = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] i,
                            input logic [31:0] pc, input logic [AW-1:0] a);
    cmp({name, "_valid"}, 32'(inst_valid), 32'(v));
    cmp({name, "_inst"}, inst, i);
    if (v) cmp({name, "_pc"}, inst_pc, pc);
    cmp({name, "_adra"}, 32'(bios_adra), 32'(a));
  endtask

  // Reset, then two plain cycles: 0x22 @ 0x4000_0004 is presented on return.
  task automatic restart_to_22();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_out("r22", 1, 32'h22, 32'h4000_0004, 12'h002);
  endtask

  logic [31:0] exp_i [4];

  initial begin
    exp_i = '{32'h11, 32'h22, 32'h33, 32'h44};
    stall = 0; reset = 1; redirect = 0; redirect_pc = 0;

    // Reset state and free run.
    step(0, 1, 0, 0);
    chk_en = 1'b1;
    step(0, 1, 0, 0);
    expect_out("rst", 0, NOP, RST, 12'h000);
    cmp("rst_pc", inst_pc, RST);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      expect_out("run", 1, exp_i[i], RST + 32'(4 * i), AW'(i + 1));
    end

    // Three-cycle stall on 0x22, then release and continue without skip/repeat.
    restart_to_22();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      expect_out("stall", 1, 32'h22, 32'h4000_0004, 12'h002);
    end
    step(0, 0, 0, 0);
    expect_out("post_stall", 1, 32'h33, 32'h4000_0008, 12'h003);
    step(0, 0, 0, 0);
    expect_out("post_stall2", 1, 32'h44, 32'h4000_000C, 12'h004);

    // Redirect with unaligned target.
    restart_to_22();
    step(0, 0, 1, 32'h4000_0102);
    expect_out("redir_bubble", 0, NOP, 0, 12'h040);
    step(0, 0, 0, 0);
    expect_out("redir_tgt", 1, 32'hC000_0040, 32'h4000_0100, 12'h041);

    // Redirect during a hold, then stall across the bubble.
    restart_to_22();
    step(1, 0, 0, 0);
    expect_out("hold", 1, 32'h22, 32'h4000_0004, 12'h002);
    step(1, 0, 1, 32'h4000_0102);
    expect_out("hredir_bubble", 0, NOP, 0, 12'h040);
    step(1, 0, 0, 0);
    expect_out("bubble_stall", 0, NOP, 0, 12'h040);
    step(0, 0, 0, 0);
    expect_out("bubble_rel", 1, 32'hC000_0040, 32'h4000_0100, 12'h041);
    step(0, 0, 0, 0);
    expect_out("bubble_next", 1, 32'hC000_0041, 32'h4000_0104, 12'h042);

    // Reset in the middle of a stall.
    restart_to_22();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    expect_out("rst_stall", 0, NOP, RST, 12'h000);
    cmp("rst_stall_pc", inst_pc, RST);
    step(0, 0, 0, 0);
    expect_out("rst_restart", 1, 32'h11, RST, 12'h001);

    // BIOS index wrap while inst_pc keeps counting.
    step(0, 0, 1, 32'h4000_3FFC);
    expect_out("wrap_bubble", 0, NOP, 0, 12'hFFF);
    step(0, 0, 0, 0);
    expect_out("wrap_last", 1, 32'hC000_0FFF, 32'h4000_3FFC, 12'h000);
    step(0, 0, 0, 0);
    expect_out("wrap_first", 1, 32'h11, 32'h4000_4000, 12'h001);

    // Mixed stall/redirect pattern, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      step((i % 5 == 2) || (i % 7 == 3), 1'b0, (i % 11 == 6), 32'h4000_0201 + 32'(8 * i));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
